// File: rtl/candidate_scheduler_if.sv
// Dispatch bundle between the candidate scheduler and the hash-core array.
// Handshake: an index moves to core i on a clock edge where core_valid[i] & core_ready[i]; core_done[i] pulses once per accepted index, qualified by core_hit[i].
interface candidate_scheduler_if #(
   parameter int NUM_CORES = 4,
   parameter int IDX_BITS  = 32
);
   logic [NUM_CORES-1:0] core_valid;
   logic [NUM_CORES-1:0] core_ready;
   logic [NUM_CORES-1:0] core_done;
   logic [NUM_CORES-1:0] core_hit;
   logic [IDX_BITS-1:0]  core_idx;

   modport master (
      output core_valid,
      output core_idx,
      input  core_ready,
      input  core_done,
      input  core_hit
   );

   modport slave (
      input  core_valid,
      input  core_idx,
      output core_ready,
      output core_done,
      output core_hit
   );
endinterface

// File: rtl/candidate_scheduler.sv
// Walks an inclusive candidate-index range, hands one index per cycle to the next ready
// hash core in round-robin order, and stops on the first reported hit.
module candidate_scheduler #(
   parameter int NUM_CORES = 4,
   parameter int IDX_BITS  = 32
) (
   input  logic                          clk,
   input  logic                          n_rst,
   input  logic                          start,
   input  logic                          abort,
   input  logic [IDX_BITS-1:0]           range_start,
   input  logic [IDX_BITS-1:0]           range_end,
   candidate_scheduler_if.master         core,
   output logic                          busy,
   output logic                          found,
   output logic                          exhausted,
   output logic [IDX_BITS-1:0]           found_idx,
   output logic [IDX_BITS:0]             issued_count,
   output logic [1:0]                    dbg_state,
   output logic [$clog2(NUM_CORES)-1:0]  dbg_rr_ptr
);
   localparam int PTR_W = $clog2(NUM_CORES);
   localparam int OUT_W = $clog2(NUM_CORES + 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DISPATCH = 2'd1,
      S_DRAIN    = 2'd2,
      S_DONE     = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IDX_BITS-1:0]  next_idx_q, next_idx_d;
   logic [IDX_BITS-1:0]  range_end_q, range_end_d;
   logic [IDX_BITS-1:0]  tag_q [NUM_CORES];
   logic [IDX_BITS-1:0]  tag_d [NUM_CORES];
   logic [IDX_BITS:0]    issued_count_q, issued_count_d;
   logic [OUT_W-1:0]     outstanding_q, outstanding_d;
   logic                 last_q, last_d;
   logic                 found_q, found_d;
   logic                 exhausted_q, exhausted_d;
   logic [IDX_BITS-1:0]  found_idx_q, found_idx_d;

   logic [NUM_CORES-1:0] grant;
   logic [PTR_W-1:0]     grant_id;
   logic                 grant_any;
   logic                 sweep_active;
   logic [NUM_CORES-1:0] hit_vec;
   logic                 hit_any;
   logic [PTR_W-1:0]     hit_id;
   int                   done_cnt;
   int                   cand;
   int                   out_next;

   // Round-robin grant: first ready core at or after rr_ptr, wrapping.
   always_comb begin
      grant     = '0;
      grant_id  = '0;
      grant_any = 1'b0;
      cand      = 0;
      if (state_q == S_DISPATCH && !last_q) begin
         for (int k = 0; k < NUM_CORES; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_CORES) cand = cand - NUM_CORES;
            if (!grant_any && core.core_ready[cand]) begin
               grant_any   = 1'b1;
               grant_id    = PTR_W'(cand);
               grant[cand] = 1'b1;
            end
         end
      end
   end

   // Result pulses only count while a sweep is live; lowest-numbered hit wins.
   always_comb begin
      sweep_active = (state_q == S_DISPATCH) || (state_q == S_DRAIN);
      hit_vec      = sweep_active ? (core.core_done & core.core_hit) : '0;
      hit_any      = |hit_vec;
      hit_id       = '0;
      done_cnt     = 0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (hit_vec[i]) hit_id = PTR_W'(i);
      end
      for (int i = 0; i < NUM_CORES; i++) begin
         if (sweep_active && core.core_done[i]) done_cnt = done_cnt + 1;
      end
   end

   always_comb begin
      state_d        = state_q;
      rr_ptr_d       = rr_ptr_q;
      next_idx_d     = next_idx_q;
      range_end_d    = range_end_q;
      issued_count_d = issued_count_q;
      outstanding_d  = outstanding_q;
      last_d         = last_q;
      found_d        = found_q;
      exhausted_d    = exhausted_q;
      found_idx_d    = found_idx_q;
      for (int i = 0; i < NUM_CORES; i++) tag_d[i] = tag_q[i];
      out_next = int'(outstanding_q) + (grant_any ? 1 : 0) - done_cnt;

      if (grant_any) begin
         tag_d[grant_id] = next_idx_q;
         next_idx_d      = next_idx_q + IDX_BITS'(1);
         rr_ptr_d        = (int'(grant_id) == NUM_CORES - 1) ? '0 : grant_id + PTR_W'(1);
         issued_count_d  = issued_count_q + (IDX_BITS + 1)'(1);
         if (next_idx_q == range_end_q) last_d = 1'b1;
      end
      if (sweep_active) outstanding_d = OUT_W'(out_next);
      if (hit_any && !found_q) begin
         found_d     = 1'b1;
         found_idx_d = tag_q[hit_id];
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               range_end_d    = range_end;
               next_idx_d     = range_start;
               issued_count_d = '0;
               outstanding_d  = '0;
               last_d         = 1'b0;
               found_d        = 1'b0;
               found_idx_d    = '0;
               exhausted_d    = (range_start > range_end);
               state_d        = (range_start > range_end) ? S_DONE : S_DISPATCH;
            end
         end
         S_DISPATCH: begin
            // The last flag, not next_idx, ends the walk so an all-ones end never wraps into a re-issue.
            if (last_d || hit_any) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (outstanding_q == '0) begin
               state_d     = S_DONE;
               exhausted_d = ~found_d;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (abort) begin
         state_d       = S_IDLE;
         found_d       = 1'b0;
         exhausted_d   = 1'b0;
         outstanding_d = '0;
         last_d        = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q        <= S_IDLE;
         rr_ptr_q       <= '0;
         next_idx_q     <= '0;
         range_end_q    <= '0;
         issued_count_q <= '0;
         outstanding_q  <= '0;
         last_q         <= 1'b0;
         found_q        <= 1'b0;
         exhausted_q    <= 1'b0;
         found_idx_q    <= '0;
         for (int i = 0; i < NUM_CORES; i++) tag_q[i] <= '0;
      end else begin
         state_q        <= state_d;
         rr_ptr_q       <= rr_ptr_d;
         next_idx_q     <= next_idx_d;
         range_end_q    <= range_end_d;
         issued_count_q <= issued_count_d;
         outstanding_q  <= outstanding_d;
         last_q         <= last_d;
         found_q        <= found_d;
         exhausted_q    <= exhausted_d;
         found_idx_q    <= found_idx_d;
         for (int i = 0; i < NUM_CORES; i++) tag_q[i] <= tag_d[i];
      end
   end

   assign core.core_valid = grant;
   assign core.core_idx   = next_idx_q;
   assign busy            = (state_q == S_DISPATCH) || (state_q == S_DRAIN);
   assign found           = found_q;
   assign exhausted       = exhausted_q;
   assign found_idx       = found_idx_q;
   assign issued_count    = issued_count_q;
   assign dbg_state       = state_q;
   assign dbg_rr_ptr      = rr_ptr_q;
endmodule

// File: tb/tb_candidate_scheduler.sv
// Directed bench for candidate_scheduler: behavioural hash cores, an expected-dispatch
// queue filled by the stimulus, and a monitor that pops it on every handshake.
module tb_candidate_scheduler;
   localparam int NC = 4;
   localparam int IW = 32;
   localparam int W  = 40;
   localparam logic [1:0] ST_IDLE = 2'd0, ST_DISP = 2'd1, ST_DRAIN = 2'd2, ST_DONE = 2'd3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           n_rst, start, abort;
   logic [IW-1:0]  range_start, range_end;
   logic           busy, found, exhausted;
   logic [IW-1:0]  found_idx;
   logic [IW:0]    issued_count;
   logic [1:0]     dbg_state;
   logic [1:0]     dbg_rr_ptr;

   candidate_scheduler_if #(.NUM_CORES(NC), .IDX_BITS(IW)) cif ();

   candidate_scheduler #(.NUM_CORES(NC), .IDX_BITS(IW)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .start        (start),
      .abort        (abort),
      .range_start  (range_start),
      .range_end    (range_end),
      .core         (cif),
      .busy         (busy),
      .found        (found),
      .exhausted    (exhausted),
      .found_idx    (found_idx),
      .issued_count (issued_count),
      .dbg_state    (dbg_state),
      .dbg_rr_ptr   (dbg_rr_ptr)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [W-1:0] exp_q[$];

   // core model controls
   logic [NC-1:0] ready_en, hit_mask, m_busy;
   logic          hit_any;
   logic [IW-1:0] hit_val;
   int            lat [NC];
   int            m_cnt [NC];
   logic [IW-1:0] m_idx [NC];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int core_n, input logic [IW-1:0] idx);
      exp_q.push_back({8'(core_n), idx});
   endtask

   // Core model: inputs change only on negedge; accepted handshakes are read 1 unit later.
   always @(negedge clk) begin
      logic [NC-1:0] rdy_v, done_v, hit_v, hs;
      done_v = '0;
      hit_v  = '0;
      if (!n_rst) m_busy = '0;
      else begin
         for (int i = 0; i < NC; i++) begin
            if (m_busy[i]) begin
               m_cnt[i] = m_cnt[i] - 1;
               if (m_cnt[i] == 0) begin
                  m_busy[i] = 1'b0;
                  done_v[i] = 1'b1;
                  hit_v[i]  = hit_mask[i] && (hit_any || m_idx[i] == hit_val);
               end
            end
         end
      end
      for (int i = 0; i < NC; i++) rdy_v[i] = ready_en[i] & ~m_busy[i];
      cif.core_ready = rdy_v;
      cif.core_done  = done_v;
      cif.core_hit   = hit_v;
      #1;
      hs = cif.core_valid & cif.core_ready;
      if (n_rst) begin
         for (int i = 0; i < NC; i++) begin
            if (hs[i]) begin
               m_busy[i] = 1'b1;
               m_cnt[i]  = lat[i];
               m_idx[i]  = cif.core_idx;
            end
         end
      end
   end

   // Monitor: every transfer must match the head of the expected queue.
   always @(negedge clk) begin
      logic [NC-1:0] hs;
      logic [W-1:0]  got, exp;
      int            cn;
      #1;
      if (n_rst) begin
         hs = cif.core_valid & cif.core_ready;
         if (found) check("no_valid_after_hit", 64'(cif.core_valid), 64'd0);
         if (hs != '0) begin
            cn = 0;
            for (int i = NC - 1; i >= 0; i--) if (hs[i]) cn = i;
            got = {8'(cn), cif.core_idx};
            check("valid_onehot", 64'($onehot(cif.core_valid)), 64'd1);
            if (exp_q.size() == 0) begin
               check("unexpected_dispatch", 64'(got), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               exp = exp_q.pop_front();
               check("dispatch_core_idx", 64'(got), 64'(exp));
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      n_rst = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
   endtask

   task automatic start_sweep(input logic [IW-1:0] s, input logic [IW-1:0] e);
      range_start = s;
      range_end   = e;
      start       = 1'b1;
      @(negedge clk);
      start       = 1'b0;
   endtask

   task automatic wait_state(input string name, input logic [1:0] st, input int max_cyc);
      int n = 0;
      while (dbg_state != st && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(dbg_state), 64'(st));
   endtask

   task automatic wait_found(input string name, input int max_cyc);
      int n = 0;
      while (!found && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(found), 64'd1);
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
      check({tag, "_rr_ptr"}, 64'(dbg_rr_ptr), 64'd0);
      check({tag, "_outputs"}, {busy, found, exhausted, cif.core_valid},
            64'd0);
      check({tag, "_found_idx"}, 64'(found_idx), 64'd0);
      check({tag, "_issued"}, 64'(issued_count), 64'd0);
      check({tag, "_core_idx"}, 64'(cif.core_idx), 64'd0);
   endtask

   task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
      lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
   endtask

   initial begin
      n_rst = 1'b0; start = 1'b0; abort = 1'b0;
      range_start = '0; range_end = '0;
      cif.core_ready = '0; cif.core_done = '0; cif.core_hit = '0;
      ready_en = '1; hit_mask = '0; hit_any = 1'b0; hit_val = '0; m_busy = '0;
      set_lat(3, 3, 3, 3);

      do_reset();
      check_idle_zero("reset");

      // Reset mid-sweep: only core 0 takes work, so the block sits in DISPATCH.
      ready_en = 4'b0001;
      set_lat(50, 3, 3, 3);
      push(0, 0);
      start_sweep(0, 99);
      check("mid_state_dispatch", 64'(dbg_state), 64'(ST_DISP));
      repeat (3) @(negedge clk);
      check("mid_issued", 64'(issued_count), 64'd1);
      check("mid_busy", 64'(busy), 64'd1);
      do_reset();
      check_idle_zero("mid_reset");
      ready_en = '1;
      set_lat(3, 3, 3, 3);

      // Full sweep 10..17, no hit.
      for (int k = 0; k < 8; k++) push(k % 4, 32'(10 + k));
      start_sweep(10, 17);
      check("sweep_dispatch_t1", 64'(dbg_state), 64'(ST_DISP));
      wait_state("sweep_done", ST_DONE, 60);
      check("sweep_flags", {found, exhausted, busy}, 64'b010);
      check("sweep_issued", 64'(issued_count), 64'd8);
      check("sweep_queue_empty", 64'(exp_q.size()), 64'd0);

      // Hit on index 6 from core 2, then drain.
      do_reset();
      hit_mask = 4'b0100; hit_val = 32'd6;
      for (int k = 0; k < 10; k++) push(k % 4, 32'(k));
      start_sweep(0, 99);
      wait_found("hit_seen", 60);
      check("hit_state_drain", 64'(dbg_state), 64'(ST_DRAIN));
      wait_state("hit_done", ST_DONE, 60);
      check("hit_flags", {found, exhausted, busy}, 64'b100);
      check("hit_found_idx", 64'(found_idx), 64'd6);
      check("hit_issued", 64'(issued_count), 64'd10);
      check("hit_queue_empty", 64'(exp_q.size()), 64'd0);

      // Cores 1 and 3 hit in the same cycle; core 1's tag (21) wins.
      do_reset();
      hit_mask = 4'b1010; hit_any = 1'b1;
      set_lat(3, 5, 3, 3);
      push(0, 20); push(1, 21); push(2, 22); push(3, 23);
      push(0, 24); push(2, 25); push(3, 26);
      start_sweep(20, 39);
      wait_state("simul_done", ST_DONE, 60);
      check("simul_found_idx", 64'(found_idx), 64'd21);
      check("simul_flags", {found, exhausted}, 64'b10);
      check("simul_issued", 64'(issued_count), 64'd7);
      check("simul_queue_empty", 64'(exp_q.size()), 64'd0);

      // Single all-ones index: one dispatch, no wrap re-issue.
      do_reset();
      hit_mask = '0; hit_any = 1'b0;
      set_lat(3, 3, 3, 3);
      push(0, 32'hFFFF_FFFF);
      start_sweep(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_state("ones_done", ST_DONE, 30);
      repeat (4) @(negedge clk);
      check("ones_flags", {found, exhausted}, 64'b01);
      check("ones_issued", 64'(issued_count), 64'd1);
      check("ones_queue_empty", 64'(exp_q.size()), 64'd0);

      // Degenerate range straight from DONE.
      start_sweep(5, 4);
      check("degen_state", 64'(dbg_state), 64'(ST_DONE));
      check("degen_flags", {busy, found, exhausted}, 64'b001);
      check("degen_issued", 64'(issued_count), 64'd0);

      // Abort in DRAIN with two outstanding, stale dones in IDLE, then restart.
      do_reset();
      set_lat(2, 6, 6, 6);
      hit_mask = 4'b0001; hit_val = 32'd0;
      push(0, 0); push(1, 1); push(2, 2);
      start_sweep(0, 99);
      wait_found("abort_hit_seen", 20);
      check("abort_pre_state", 64'(dbg_state), 64'(ST_DRAIN));
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_state", 64'(dbg_state), 64'(ST_IDLE));
      check("abort_flags", {busy, found, exhausted}, 64'b000);
      repeat (6) @(negedge clk);
      check("abort_stale_ignored", 64'(dbg_state), 64'(ST_IDLE));
      check("abort_rr_ptr", 64'(dbg_rr_ptr), 64'd3);
      hit_mask = '0;
      set_lat(3, 3, 3, 3);
      push(3, 50); push(0, 51); push(1, 52);
      start_sweep(50, 52);
      wait_state("restart_done", ST_DONE, 40);
      check("restart_flags", {found, exhausted}, 64'b01);
      check("restart_issued", 64'(issued_count), 64'd3);
      check("restart_queue_empty", 64'(exp_q.size()), 64'd0);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
